// File: rtl/uaz_pkg.sv
// Shared UAZ definitions: LSU state encoding, bus RW polarity and default widths
// used by the load/store unit, register bank and control unit.
package uaz_pkg;

  localparam int unsigned UAZ_DATA_W = 8;
  localparam int unsigned UAZ_ADDR_W = 8;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } uaz_lsu_state_e;

endpackage

// File: rtl/uaz_wait_timer.sv
// Wait-state counter for the LSU: counts BUS cycles without acknowledge and
// flags expiry on the cycle the count reaches TIMEOUT.
module uaz_wait_timer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Expiry is flagged in the same cycle the increment takes the count to TIMEOUT.
  assign expired_o = enable_i && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uaz_bus_lsu.sv
// UAZ load/store bus unit: one strobe/ack transfer per core request, all outputs registered.
// Optional wait-state abort is compiled in with `define UAZ_LSU_TIMEOUT_EN.
module uaz_bus_lsu
  import uaz_pkg::*;
#(
  parameter int unsigned DATA_W  = UAZ_DATA_W,
  parameter int unsigned ADDR_W  = UAZ_ADDR_W,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              i_Req,
  input  logic              i_We,
  input  logic [ADDR_W-1:0] i_Addr,
  input  logic [DATA_W-1:0] i_Wdata,
  output logic              o_Busy,
  output logic              o_Done,
  output logic              o_Err,
  output logic [DATA_W-1:0] o_Rdata,
  output logic [ADDR_W-1:0] o_Addres_Data_Bus,
  output logic [DATA_W-1:0] o_DataOut_Bus,
  output logic              o_RW,
  output logic              o_Strobe,
  input  logic              i_Ack,
  input  logic [DATA_W-1:0] i_Dato_Bus
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("uaz_bus_lsu: TIMEOUT must be at least 1");
  end

  uaz_lsu_state_e    state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rw_q, rw_d;
  logic              strobe_q, busy_q, done_q;

`ifdef UAZ_LSU_TIMEOUT_EN
  logic tmo_expired;
  logic err_q, err_d;

  uaz_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk_i     (Clk),
    .rst_i     (Rst),
    .clear_i   ((state_q == IDLE) && i_Req),
    .enable_i  ((state_q == BUS) && !i_Ack),
    .expired_o (tmo_expired)
  );

  assign o_Err = err_q;
`else
  assign o_Err = 1'b0;
`endif

  // Bus-side values are latched straight into the output registers on acceptance,
  // so the request fields need no separate holding registers.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    dout_d  = '0;
    rw_d    = RW_READ;
    rdata_d = rdata_q;
`ifdef UAZ_LSU_TIMEOUT_EN
    err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (i_Req) begin
          state_d = BUS;
          addr_d  = i_Addr;
          rw_d    = i_We ? RW_WRITE : RW_READ;
          dout_d  = i_We ? i_Wdata : '0;
        end
      end
      BUS: begin
        if (i_Ack) begin
          state_d = DONE;
          if (rw_q == RW_READ) begin
            rdata_d = i_Dato_Bus;
          end
`ifdef UAZ_LSU_TIMEOUT_EN
        end else if (tmo_expired) begin
          state_d = DONE;
          err_d   = 1'b1;
`endif
        end else begin
          rw_d   = rw_q;
          dout_d = dout_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      dout_q   <= '0;
      rdata_q  <= '0;
      rw_q     <= RW_READ;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef UAZ_LSU_TIMEOUT_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      dout_q   <= dout_d;
      rdata_q  <= rdata_d;
      rw_q     <= rw_d;
      strobe_q <= (state_d == BUS);
      busy_q   <= (state_d != IDLE);
      done_q   <= (state_d == DONE);
`ifdef UAZ_LSU_TIMEOUT_EN
      err_q    <= err_d;
`endif
    end
  end

  assign o_Busy            = busy_q;
  assign o_Done            = done_q;
  assign o_Rdata           = rdata_q;
  assign o_Addres_Data_Bus = addr_q;
  assign o_DataOut_Bus     = dout_q;
  assign o_RW              = rw_q;
  assign o_Strobe          = strobe_q;

endmodule

// File: tb/tb_uaz_bus_lsu.sv
// Self-checking bench for uaz_bus_lsu: transaction-level expected outputs derived
// from the handshake timing rules, compared every cycle, plus literal pins.
module tb_uaz_bus_lsu;

  localparam int TMO = 15;
`ifdef UAZ_LSU_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Rst;
  logic       i_Req, i_We, i_Ack;
  logic [7:0] i_Addr, i_Wdata, i_Dato_Bus;
  logic       o_Busy, o_Done, o_Err, o_RW, o_Strobe;
  logic [7:0] o_Rdata, o_Addres_Data_Bus, o_DataOut_Bus;

  uaz_bus_lsu #(
    .DATA_W  (8),
    .ADDR_W  (8),
    .TIMEOUT (TMO)
  ) dut (
    .Clk               (Clk),
    .Rst               (Rst),
    .i_Req             (i_Req),
    .i_We              (i_We),
    .i_Addr            (i_Addr),
    .i_Wdata           (i_Wdata),
    .o_Busy            (o_Busy),
    .o_Done            (o_Done),
    .o_Err             (o_Err),
    .o_Rdata           (o_Rdata),
    .o_Addres_Data_Bus (o_Addres_Data_Bus),
    .o_DataOut_Bus     (o_DataOut_Bus),
    .o_RW              (o_RW),
    .o_Strobe          (o_Strobe),
    .i_Ack             (i_Ack),
    .i_Dato_Bus        (i_Dato_Bus)
  );

  always #5 Clk = ~Clk;

  // expected outputs for the current cycle
  logic       exp_strobe, exp_busy, exp_done, exp_err, exp_rw;
  logic [7:0] exp_addr, exp_dout, exp_rdata;
  // model memory: last bus address and last successful load data
  logic [7:0] m_addr, m_rdata;

  logic       chk_en = 1'b0;
  logic       pin_en = 1'b0;
  string      pin_name;
  logic [7:0] pin_rdata;
  int         pin_dones;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (chk_en) begin
      chk("strobe", 32'(o_Strobe), 32'(exp_strobe));
      chk("busy",   32'(o_Busy),   32'(exp_busy));
      chk("done",   32'(o_Done),   32'(exp_done));
      chk("err",    32'(o_Err),    32'(exp_err));
      chk("rw",     32'(o_RW),     32'(exp_rw));
      chk("addr",   32'(o_Addres_Data_Bus), 32'(exp_addr));
      chk("dout",   32'(o_DataOut_Bus),     32'(exp_dout));
      chk("rdata",  32'(o_Rdata),  32'(exp_rdata));
      if (pin_en) begin
        chk({pin_name, "_rdata"}, 32'(o_Rdata), 32'(pin_rdata));
        chk({pin_name, "_dones"}, 32'(done_cnt), 32'(pin_dones));
      end
      if (o_Done === 1'b1) done_cnt++;
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
    pin_en = 1'b0;
  endtask

  task automatic pin(input string nm, input logic [7:0] rd, input int dones);
    pin_name  = nm;
    pin_rdata = rd;
    pin_dones = dones;
    pin_en    = 1'b1;
  endtask

  task automatic set_idle();
    exp_strobe = 1'b0; exp_busy = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
    exp_rw = 1'b1; exp_dout = 8'h00; exp_addr = m_addr; exp_rdata = m_rdata;
  endtask

  task automatic set_bus(input logic we, input logic [7:0] addr, input logic [7:0] wdata);
    exp_strobe = 1'b1; exp_busy = 1'b1; exp_done = 1'b0; exp_err = 1'b0;
    exp_rw = ~we; exp_dout = we ? wdata : 8'h00; exp_addr = addr; exp_rdata = m_rdata;
  endtask

  // Starts in an IDLE cycle, ends in the IDLE cycle after DONE.
  // waits = strobe cycles without ack before the ack cycle; stray = strobe cycle
  // in which a foreign request is pulsed (0 = none).
  task automatic xfer(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                      input int waits, input logic [7:0] bus_d, input int stray);
    bit to;
    int nstrobe;
    to      = TMO_EN && (waits >= TMO);
    nstrobe = to ? TMO : waits + 1;
    i_Req = 1'b1; i_We = we; i_Addr = addr; i_Wdata = wdata;
    step();
    i_Req = 1'b0; i_We = ~we; i_Addr = ~addr; i_Wdata = ~wdata;
    m_addr = addr;
    for (int k = 1; k <= nstrobe; k++) begin
      set_bus(we, addr, wdata);
      i_Ack      = (k == waits + 1);
      i_Dato_Bus = (k == waits + 1) ? bus_d : 8'(k * 37 + 1);
      i_Req      = (stray != 0) && (k == stray);
      if (i_Req) i_Addr = 8'hEE;
      step();
    end
    if (!we && !to) m_rdata = bus_d;
    exp_strobe = 1'b0; exp_busy = 1'b1; exp_done = 1'b1; exp_err = to;
    exp_rw = 1'b1; exp_dout = 8'h00; exp_addr = m_addr; exp_rdata = m_rdata;
    i_Ack = 1'b1; i_Dato_Bus = 8'hFF; i_Req = (stray != 0);
    step();
    i_Ack = 1'b0; i_Req = 1'b0; i_Dato_Bus = 8'h00;
    set_idle();
  endtask

  initial begin
    Rst = 1'b1; i_Req = 1'b0; i_We = 1'b0; i_Ack = 1'b0;
    i_Addr = 8'h00; i_Wdata = 8'h00; i_Dato_Bus = 8'h00;
    m_addr = 8'h00; m_rdata = 8'h00;
    set_idle();
    step();
    step();
    chk_en = 1'b1;
    Rst = 1'b0;
    pin("reset", 8'h00, 0);

    for (int i = 0; i < 5; i++) begin
      i_Ack = i[0];
      i_Dato_Bus = 8'h77;
      step();
    end
    i_Ack = 1'b0;

    xfer(1'b0, 8'h3C, 8'h00, 0, 8'hA5, 0);
    pin("zw_load", 8'hA5, 1);
    xfer(1'b1, 8'h10, 8'h5A, 4, 8'h00, 0);
    pin("store_w4", 8'hA5, 2);
    xfer(1'b0, 8'h22, 8'h00, 3, 8'hC3, 2);
    pin("req_busy", 8'hC3, 3);
    xfer(1'b1, 8'h44, 8'h99, 0, 8'h00, 0);
    xfer(1'b0, 8'h45, 8'h00, 0, 8'h3E, 0);
    pin("b2b", 8'h3E, 5);

`ifdef UAZ_LSU_TIMEOUT_EN
    xfer(1'b0, 8'h81, 8'h00, 40, 8'h11, 0);
    pin("timeout", 8'h3E, 6);
    xfer(1'b0, 8'h82, 8'h00, 14, 8'h7E, 0);
    pin("ack_15th", 8'h7E, 7);
`else
    xfer(1'b1, 8'h80, 8'hF0, 20, 8'h00, 0);
    xfer(1'b0, 8'h82, 8'h00, 2, 8'h7E, 0);
    pin("long_wait", 8'h7E, 7);
`endif

    // reset during the second strobe cycle of a load
    i_Req = 1'b1; i_We = 1'b0; i_Addr = 8'h66;
    step();
    i_Req = 1'b0;
    m_addr = 8'h66;
    set_bus(1'b0, 8'h66, 8'h00);
    step();
    set_bus(1'b0, 8'h66, 8'h00);
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    m_addr = 8'h00; m_rdata = 8'h00;
    set_idle();
    pin("rst_mid", 8'h00, 7);
    step();

    xfer(1'b0, 8'h5F, 8'h00, 1, 8'h69, 0);
    pin("after_rst", 8'h69, 8);
    step();

    @(negedge Clk);
    #1;
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
